// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: strobes reads, absorbs the 1-cycle RAM latency,
// and streams words out through a 2-entry skid buffer. Define FIFO_RD_STATS_EN to add stall_cnt.
module fifo_rd_stream #(
   parameter int WIDTH     = 32,
   parameter int BURST_LEN = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          fifo_empty,
   input  logic [WIDTH-1:0]              fifo_rdata,
   output logic                          fifo_rd_en,
   input  logic                          hold,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [WIDTH-1:0]              m_data,
   output logic                          m_last,
   output logic [$clog2(BURST_LEN)-1:0]  beat_idx
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [15:0]                   stall_cnt
`endif
);

   localparam int             BW       = $clog2(BURST_LEN);
   localparam logic [BW-1:0]  LAST_IDX = BW'(BURST_LEN - 1);

   logic [1:0]        r_occ;
   logic              r_inflight;
   logic [WIDTH-1:0]  r_buf [2];
   logic              r_head;
   logic              r_tail;
   logic [BW-1:0]     r_bcnt;

   logic              w_pop;
   logic [2:0]        w_level;
   logic [1:0]        w_occ_next;
   logic              w_rd_en;
   logic [BW-1:0]     w_bcnt_next;

   // Handshake, occupancy projection, read-issue decision and beat counter update.
   always_comb begin
      w_pop       = 1'b0;
      w_level     = 3'd0;
      w_occ_next  = r_occ;
      w_rd_en     = 1'b0;
      w_bcnt_next = r_bcnt;

      w_pop      = (r_occ != 2'd0) & m_ready;
      // occ + inflight - pop: words owned by this stage after the coming edge
      w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_occ_next = w_level[1:0];

      // reset gates the strobe so it drops the instant reset asserts
      if (reset && !fifo_empty && !hold && (w_level < 3'd2)) begin
         w_rd_en = 1'b1;
      end else begin
         w_rd_en = 1'b0;
      end

      if (w_pop) begin
         if (r_bcnt == LAST_IDX) begin
            w_bcnt_next = {BW{1'b0}};
         end else begin
            w_bcnt_next = r_bcnt + BW'(1);
         end
      end else begin
         w_bcnt_next = r_bcnt;
      end
   end

   // Control state: occupancy, in-flight flag, head/tail pointers, burst beat counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
         r_head     <= 1'b0;
         r_tail     <= 1'b0;
         r_bcnt     <= {BW{1'b0}};
      end else begin
         r_occ      <= w_occ_next;
         r_inflight <= w_rd_en;
         r_bcnt     <= w_bcnt_next;
         if (r_inflight) begin
            r_tail <= ~r_tail;
         end else begin
            r_tail <= r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end else begin
            r_head <= r_head;
         end
      end
   end

   // Skid buffer storage; cleared on reset so m_data reads zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            r_buf[i] <= {WIDTH{1'b0}};
         end
      end else if (r_inflight) begin
         r_buf[r_tail] <= fifo_rdata;
      end else begin
         r_buf[r_tail] <= r_buf[r_tail];
      end
   end

   assign fifo_rd_en = w_rd_en;
   assign m_valid    = (r_occ != 2'd0);
   assign m_data     = r_buf[r_head];
   assign m_last     = (r_occ != 2'd0) & (r_bcnt == LAST_IDX);
   assign beat_idx   = r_bcnt;

`ifdef FIFO_RD_STATS_EN
   logic [15:0] r_stall;

   // Saturating count of cycles where a beat is offered but not accepted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall <= 16'd0;
      end else if ((r_occ != 2'd0) && !m_ready && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 16'd1;
      end else begin
         r_stall <= r_stall;
      end
   end

   assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: FIFO source model, in-order scoreboard on every pop,
// and hand-timed checks for reset, latency, streaming, backpressure, hold and stall stats.
module tb_fifo_rd_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic        fifo_empty;
   logic [31:0] fifo_rdata = 32'd0;
   logic        fifo_rd_en;
   logic        hold;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;
   logic [2:0]  beat_idx;
`ifdef FIFO_RD_STATS_EN
   logic [15:0] stall_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] words [0:1023];
   int          wr_cnt  = 0;
   int          rd_ptr  = 0;
   int          exp_idx = 0;
   int          exp_bcnt = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data = 32'd0;
   logic        prev_last = 1'b0;

   fifo_rd_stream #(.WIDTH(32), .BURST_LEN(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_rd_en (fifo_rd_en),
      .hold       (hold),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .beat_idx   (beat_idx)
`ifdef FIFO_RD_STATS_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // FIFO read port model: registered read data, one cycle after the strobe.
   assign fifo_empty = (rd_ptr >= wr_cnt);
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rdata <= words[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Called away from the edge with m_ready already set: score a pop, stability, level.
   task automatic sb_cycle();
      chk_eq("lvl", 32'((rd_ptr - exp_idx) > 2), 32'd0);
      if (prev_stall) begin
         chk_eq("stable_data", m_data, prev_data);
         chk_eq("stable_last", 32'(m_last), 32'(prev_last));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
         chk_eq("data", m_data, words[exp_idx]);
         chk_eq("last", 32'(m_last), 32'(exp_bcnt == 7));
         chk_eq("idx", 32'(beat_idx), 32'(exp_bcnt));
         exp_idx++;
         exp_bcnt = (exp_bcnt + 1) % 8;
      end
      tick();
   endtask

   initial begin
      int first_c, last_c, npop, nlast, nrd;

      // reset state, strobe gated even with data available
      reset = 1'b0; hold = 1'b0; m_ready = 1'b0;
      #2;
      chk_eq("rst_v", 32'(m_valid), 32'd0);
      chk_eq("rst_l", 32'(m_last), 32'd0);
      chk_eq("rst_d", m_data, 32'd0);
      chk_eq("rst_idx", 32'(beat_idx), 32'd0);
      words[0] = 32'd0;
      wr_cnt = 1;
      #1;
      chk_eq("rst_rd", 32'(fifo_rd_en), 32'd0);
      wr_cnt = 0;
      tick();
      tick();
      reset = 1'b1;

      // streaming 16 words, burst of 8
      for (int i = 0; i < 16; i++) words[i] = 32'(i);
      m_ready = 1'b1;
      wr_cnt = 16;
      first_c = -1; last_c = -1; npop = 0; nlast = 0;
      for (int c = 0; c < 40 && exp_idx < 16; c++) begin
         if (m_valid && m_ready) begin
            if (first_c < 0) first_c = c;
            last_c = c;
            npop++;
            if (m_last) nlast++;
         end
         sb_cycle();
      end
      chk_eq("st_cnt", 32'(npop), 32'd16);
      chk_eq("st_contig", 32'(last_c - first_c), 32'd15);
      chk_eq("st_lastcnt", 32'(nlast), 32'd2);
      tick();

      // single word latency
      words[16] = 32'hA5A5_0001;
      wr_cnt = 17;
      #1;
      chk_eq("sw_rd0", 32'(fifo_rd_en), 32'd1);
      sb_cycle();
      chk_eq("sw_v1", 32'(m_valid), 32'd0);
      chk_eq("sw_rd1", 32'(fifo_rd_en), 32'd0);
      sb_cycle();
      chk_eq("sw_v2", 32'(m_valid), 32'd1);
      chk_eq("sw_d2", m_data, 32'hA5A5_0001);
      sb_cycle();
      chk_eq("sw_v3", 32'(m_valid), 32'd0);
      chk_eq("sw_nrd", 32'(rd_ptr), 32'd17);
      chk_eq("sw_idx", 32'(beat_idx), 32'd1);

      // backpressure: fill to two, then random ready
      m_ready = 1'b0;
      for (int i = 17; i < 217; i++) words[i] = $urandom;
      wr_cnt = 217;
      for (int c = 0; c < 5; c++) sb_cycle();
      chk_eq("bp_full_rd", 32'(fifo_rd_en), 32'd0);
      chk_eq("bp_full_lvl", 32'(rd_ptr - exp_idx), 32'd2);
      chk_eq("bp_full_v", 32'(m_valid), 32'd1);
      for (int c = 0; c < 3000 && exp_idx < 217; c++) begin
         m_ready = 1'($urandom_range(0, 1));
         sb_cycle();
      end
      chk_eq("bp_done", 32'(exp_idx), 32'd217);

      // hold with one word in flight
      for (int i = 217; i < 220; i++) words[i] = 32'hC0DE_0000 + 32'(i);
      m_ready = 1'b1;
      wr_cnt = 220;
      sb_cycle();
      hold = 1'b1;
      #1;
      chk_eq("hold_rd", 32'(fifo_rd_en), 32'd0);
      nrd = 0;
      for (int c = 0; c < 6; c++) begin
         if (fifo_rd_en) nrd++;
         sb_cycle();
      end
      chk_eq("hold_nord", 32'(nrd), 32'd0);
      chk_eq("hold_deliv", 32'(exp_idx), 32'd218);
      hold = 1'b0;
      for (int c = 0; c < 20 && exp_idx < 220; c++) sb_cycle();
      chk_eq("hold_done", 32'(exp_idx), 32'd220);

      // reset mid-stream with two words buffered
      for (int i = 220; i < 230; i++) words[i] = 32'hDEAD_0000 + 32'(i);
      m_ready = 1'b0;
      wr_cnt = 230;
      for (int c = 0; c < 4; c++) sb_cycle();
      chk_eq("mr_pre_v", 32'(m_valid), 32'd1);
      chk_eq("mr_pre_idx", 32'(beat_idx), 32'd4);
      #2;
      reset = 1'b0;
      #1;
      chk_eq("mr_v", 32'(m_valid), 32'd0);
      chk_eq("mr_l", 32'(m_last), 32'd0);
      chk_eq("mr_d", m_data, 32'd0);
      chk_eq("mr_rd", 32'(fifo_rd_en), 32'd0);
      chk_eq("mr_idx", 32'(beat_idx), 32'd0);
      wr_cnt = rd_ptr;
      exp_idx = rd_ptr;
      exp_bcnt = 0;
      prev_stall = 1'b0;
      @(negedge clk);
      tick();
      reset = 1'b1;
      m_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         chk_eq("mr_nostale", 32'(m_valid), 32'd0);
         sb_cycle();
      end
      for (int i = 0; i < 4; i++) words[rd_ptr + i] = 32'hBEEF_0000 + 32'(i);
      wr_cnt = rd_ptr + 4;
      for (int c = 0; c < 30 && exp_idx < wr_cnt; c++) sb_cycle();
      chk_eq("mr_done", 32'(exp_idx), 32'(wr_cnt));

`ifdef FIFO_RD_STATS_EN
      // stall counter: 10 cycles, then saturation
      chk_eq("stat0", 32'(stall_cnt), 32'd0);
      words[wr_cnt] = 32'h5757_0000;
      m_ready = 1'b0;
      wr_cnt = wr_cnt + 1;
      for (int c = 0; c < 10 && !m_valid; c++) tick();
      chk_eq("stat_v", 32'(m_valid), 32'd1);
      chk_eq("stat_pre", 32'(stall_cnt), 32'd0);
      repeat (10) tick();
      chk_eq("stat10", 32'(stall_cnt), 32'd10);
      repeat (70000) tick();
      chk_eq("stat_sat", 32'(stall_cnt), 32'h0000_FFFF);
      prev_stall = 1'b0;
      m_ready = 1'b1;
      sb_cycle();
      chk_eq("stat_drain", 32'(exp_idx), 32'(wr_cnt));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage placed directly downstream of the asynchronous FIFO, in the read clock domain. It issues FIFO read strobes, absorbs the memory's one-cycle registered read latency, and presents the data as a valid/ready stream through a 2-entry skid buffer. A `last` flag marks the end of each fixed-length burst. No FIFO word is lost or duplicated under any backpressure pattern.

## Interface
- `WIDTH`, 32, data width; matches the FIFO data width.
- `BURST_LEN`, 8, beats per burst; `m_last` marks beat `BURST_LEN`; legal range 2..1024.
- `clk`  in  1  read-domain clock; same clock as the FIFO read side.
- `reset`  in  1  reset; asynchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag, registered in `clk` domain.
- `fifo_rdata`  in  WIDTH  FIFO read data; valid the cycle after a read strobe.
- `fifo_rd_en`  out  1  FIFO read strobe (combinational from registered state and `fifo_empty`).
- `hold`  in  1  when 1, no new FIFO reads are issued; buffered and in-flight words still drain.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  output beat data (buffer head).
- `m_last`  out  1  high with the final beat of each burst.
- `beat_idx`  out  clog2(BURST_LEN)  index of the current head beat within its burst.
- `stall_cnt`  out  16  saturating stall counter; present only with `FIFO_RD_STATS_EN`.

## Operation
- State registers:
  - `occ`: buffer occupancy, 0..2.
  - `inflight`: 1 when a read was strobed at the previous edge.
  - 2-entry buffer with 1-bit head and tail pointers.
  - beat counter `bcnt`.
- Pop: `pop = m_valid & m_ready`.
- Read issue: `fifo_rd_en = !fifo_empty & !hold & (occ + inflight - pop < 2)`.
- Capture: when `inflight` = 1, `fifo_rdata` is written at the tail and the tail advances.
- Next occupancy: `occ_next = occ + inflight - pop`. It never exceeds 2 and never underflows.
- `m_valid = (occ != 0)`. `m_data` is the head entry.
- On pop: head advances. `bcnt` increments and wraps from `BURST_LEN-1` to 0.
- `m_last = m_valid & (bcnt == BURST_LEN-1)`. `beat_idx = bcnt`.
- Simultaneous capture and pop in the same cycle: occupancy is unchanged and both pointers advance.
- `hold` only gates new strobes. A word already in flight is always captured.
- Burst framing is not reset by `hold` or by FIFO empty gaps. Only `reset` clears `bcnt`.

## Timing
- Reset (asynchronous assert, synchronous release): `occ`=0, `inflight`=0, pointers=0, `bcnt`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `fifo_rd_en`=0, `beat_idx`=0, `stall_cnt`=0.
- Latency:
  - Strobe sampled at edge N.
  - `fifo_rdata` valid after edge N.
  - Captured at edge N+1; `m_valid` high after edge N+1.
  - Minimum latency from `fifo_empty` falling to `m_valid`: 2 cycles.
- Throughput: 1 beat per cycle sustained while `m_ready`=1 and `fifo_empty`=0.
- Backpressure: with `m_ready`=0 from a streaming state, at most 2 words are strobed ahead of the consumer. `fifo_rd_en` deasserts in the same cycle that `occ + inflight` reaches 2.
- Handshake: once `m_valid` is high, `m_data` and `m_last` stay stable until a pop.
- Reset mid-operation: buffered and in-flight words are discarded, and the strobe drops immediately. Recovery of FIFO pointers is the owner's responsibility.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - Adds the `stall_cnt` port.
  - `stall_cnt` increments each cycle with `m_valid & !m_ready` and saturates at 0xFFFF.
  - It clears only on reset.
- `FIFO_RD_STATS_EN` undefined: the port and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert `reset`=0 mid-stream with 2 words buffered -> all outputs 0 within the same cycle; after release, no stale beat appears.
- Single word: `fifo_empty` low for one strobe, `m_ready`=1 -> `fifo_rd_en` high 1 cycle; `m_valid` high exactly 2 cycles after `fifo_empty` fell; data matches.
- Streaming: 16 words 0x0..0xF, `m_ready`=1, `BURST_LEN`=8 -> 16 consecutive beats in order; `m_last` on 0x7 and 0xF only.
- Backpressure: random `m_ready` at 50% over 200 words -> scoreboard exact, no loss or duplicate; `occ + inflight` never exceeds 2.
- Hold: raise `hold` with 1 word in flight -> that word is delivered; no further `fifo_rd_en` until `hold`=0; `bcnt` continues from its value.
- Stats: with `FIFO_RD_STATS_EN`, hold `m_ready`=0 for 10 cycles while `m_valid`=1 -> `stall_cnt`=10; force 70000 stall cycles -> saturates at 0xFFFF.
